// File: rtl/bufmr_ce_seq_if.sv
// bufmr_ce_seq_if
// Groups the request, lock, and buffer-control signals of one BUFMRCE/BUFR
// sequencer.
//
// Modports:
//   slave  - sequencer side. Receives START, STOP and MMCM_LOCKED.
//            Drives CE, CLR, READY, BUSY, LOCK_LOST and STATE.
//   master - controller side. The direction of every signal is reversed.
//
// Optional macro BUFMR_CE_SEQ_LOSS_CNT_EN adds the 8-bit LOSS_CNT output.
interface bufmr_ce_seq_if;
  logic       START;
  logic       STOP;
  logic       MMCM_LOCKED;
  logic       CE;
  logic       CLR;
  logic       READY;
  logic       BUSY;
  logic       LOCK_LOST;
  logic [2:0] STATE;
`ifdef BUFMR_CE_SEQ_LOSS_CNT_EN
  logic [7:0] LOSS_CNT;

  modport slave (
    input  START, STOP, MMCM_LOCKED,
    output CE, CLR, READY, BUSY, LOCK_LOST, STATE, LOSS_CNT
  );
  modport master (
    output START, STOP, MMCM_LOCKED,
    input  CE, CLR, READY, BUSY, LOCK_LOST, STATE, LOSS_CNT
  );
`else
  modport slave (
    input  START, STOP, MMCM_LOCKED,
    output CE, CLR, READY, BUSY, LOCK_LOST, STATE
  );
  modport master (
    output START, STOP, MMCM_LOCKED,
    input  CE, CLR, READY, BUSY, LOCK_LOST, STATE
  );
`endif
endinterface

// File: rtl/bufmr_ce_seq.sv
// bufmr_ce_seq
// Sequences the CE pin of a BUFMRCE and the CLR of the BUFRs it feeds, so
// that the multi-region clock starts and stops without glitches.
// The order is fixed:
//   1. The BUFRs are held in clear.
//   2. The BUFMRCE is disabled and allowed to settle.
//   3. CE is raised.
//   4. CLR is released.
// The block runs on a free-running system clock. That clock is independent
// of the buffered clock.
//
// Ports:
//   CLK - free-running system clock
//   RST - synchronous, active-high reset
//   bus - bufmr_ce_seq_if.slave. It carries:
//           inputs  START, STOP, MMCM_LOCKED (asynchronous)
//           outputs CE, CLR, READY, BUSY, LOCK_LOST, STATE[2:0]
//
// Parameters:
//   CE_DLY       - cycles CE stays low in CE_SETTLE (1..255)
//   CLR_DLY      - cycles between a CE change and the CLR change (1..255)
//   LOCK_SYNC    - synchronizer depth on MMCM_LOCKED (2..4)
//   AUTO_RESTART - 1: FAULT goes back to WAIT_LOCK instead of IDLE
//
// Optional macro BUFMR_CE_SEQ_LOSS_CNT_EN adds LOSS_CNT[7:0].
// LOSS_CNT counts entries into FAULT and saturates at 255.
// Only RST clears it.
module bufmr_ce_seq #(
  parameter int CE_DLY       = 4,
  parameter int CLR_DLY      = 8,
  parameter int LOCK_SYNC    = 2,
  parameter int AUTO_RESTART = 0
) (
  input logic           CLK,
  input logic           RST,
  bufmr_ce_seq_if.slave bus
);

  // Reject illegal parameter values when the design is elaborated.
  if (CE_DLY < 1 || CE_DLY > 255 || CLR_DLY < 1 || CLR_DLY > 255 ||
      LOCK_SYNC < 2 || LOCK_SYNC > 4 || AUTO_RESTART < 0 || AUTO_RESTART > 1)
  begin : g_param_error
    $fatal(1, "bufmr_ce_seq attribute error in %m: CE_DLY/CLR_DLY must be 1..255, LOCK_SYNC 2..4, AUTO_RESTART 0..1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_CE_SETTLE = 3'd2,
    S_CE_ON     = 3'd3,
    S_RUN       = 3'd4,
    S_STOP_CLR  = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  // The counter is loaded with (delay - 1) when a state is entered.
  // The state is left on the cycle the counter reads zero, so the state
  // lasts exactly 'delay' cycles.
  localparam logic [7:0] CE_LOAD  = 8'(CE_DLY - 1);
  localparam logic [7:0] CLR_LOAD = 8'(CLR_DLY - 1);

  logic [LOCK_SYNC-1:0] sync_q;
  logic                 lock_s;
  state_t               state_q;
  state_t               nxt;
  logic [7:0]           cnt_q;
  logic [7:0]           cnt_load;
  logic                 ce_q;
  logic                 clr_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 lost_q;
  logic                 start_accept;
  logic                 fault_entry;

  assign lock_s = sync_q[LOCK_SYNC-1];

  // Next-state decision. Requests are prioritized in this order:
  //   1. Lock loss. It beats STOP everywhere outside IDLE, WAIT_LOCK and FAULT.
  //   2. STOP.
  //   3. Counter expiry.
  // FAULT always lasts one cycle, even if lock is still missing.
  always_comb begin
    nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START && !bus.STOP) nxt = lock_s ? S_CE_SETTLE : S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (bus.STOP)    nxt = S_IDLE;
        else if (lock_s) nxt = S_CE_SETTLE;
      end
      S_CE_SETTLE: begin
        if (!lock_s)             nxt = S_FAULT;
        else if (bus.STOP)       nxt = S_IDLE;
        else if (cnt_q == 8'd0)  nxt = S_CE_ON;
      end
      S_CE_ON: begin
        if (!lock_s)             nxt = S_FAULT;
        else if (bus.STOP)       nxt = S_IDLE;
        else if (cnt_q == 8'd0)  nxt = S_RUN;
      end
      S_RUN: begin
        if (!lock_s)       nxt = S_FAULT;
        else if (bus.STOP) nxt = S_STOP_CLR;
      end
      S_STOP_CLR: begin
        if (!lock_s)            nxt = S_FAULT;
        else if (cnt_q == 8'd0) nxt = S_IDLE;
      end
      S_FAULT: begin
        nxt = (AUTO_RESTART != 0) ? S_WAIT_LOCK : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Delay to load into the counter for the state being entered.
  always_comb begin
    cnt_load = 8'd0;
    case (nxt)
      S_CE_SETTLE:         cnt_load = CE_LOAD;
      S_CE_ON, S_STOP_CLR: cnt_load = CLR_LOAD;
      default:             cnt_load = 8'd0;
    endcase
  end

  assign start_accept = (state_q == S_IDLE) && (nxt != S_IDLE);
  assign fault_entry  = (nxt == S_FAULT) && (state_q != S_FAULT);

  // Lock synchronizer, state register, delay counter and outputs.
  // The outputs are decoded from the next state. This lets every output
  // change on the same edge as STATE while still coming straight from a
  // flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= '0;
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      ce_q    <= 1'b0;
      clr_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[LOCK_SYNC-2:0], bus.MMCM_LOCKED};
      state_q <= nxt;
      if (nxt != state_q)    cnt_q <= cnt_load;
      else if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
      ce_q    <= (nxt == S_CE_ON) || (nxt == S_RUN) || (nxt == S_STOP_CLR);
      clr_q   <= (nxt != S_RUN);
      ready_q <= (nxt == S_RUN);
      busy_q  <= (nxt != S_IDLE) && (nxt != S_RUN);
      if (start_accept)     lost_q <= 1'b0;
      else if (fault_entry) lost_q <= 1'b1;
    end
  end

  assign bus.CE        = ce_q;
  assign bus.CLR       = clr_q;
  assign bus.READY     = ready_q;
  assign bus.BUSY      = busy_q;
  assign bus.LOCK_LOST = lost_q;
  assign bus.STATE     = state_q;

`ifdef BUFMR_CE_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;

  // Lifetime count of lock losses. START leaves it untouched.
  always_ff @(posedge CLK) begin
    if (RST)                                    loss_cnt_q <= 8'd0;
    else if (fault_entry && loss_cnt_q != 8'hFF) loss_cnt_q <= loss_cnt_q + 8'd1;
  end

  assign bus.LOSS_CNT = loss_cnt_q;
`endif

endmodule

// File: doc/bufmr_ce_seq.md
Name: bufmr_ce_seq

Overview:
- Sequencer that drives the CE pin of a BUFMRCE and the CLR of the BUFRs it feeds. Enables the multi-region clock glitch-free after the source MMCM locks.
- Ordering is fixed: BUFRs held in clear, BUFMRCE disabled and settled, CE raised, then CLR released.
- Runs on a free-running system clock independent of the buffered clock. Sits beside each BUFMRCE/BUFR group in the clocking block.

Parameters:
- CE_DLY, 4, cycles CE held low in CE_SETTLE before CE rises; legal 1..255.
- CLR_DLY, 8, cycles between CE change and CLR change, in both CE_ON and STOP_CLR; legal 1..255.
- LOCK_SYNC, 2, synchronizer stages on MMCM_LOCKED; legal 2..4.
- AUTO_RESTART, 0, when 1, FAULT returns to WAIT_LOCK instead of IDLE.
- Any illegal value: $display attribute error naming the instance (%m), then $finish.

Ports:
- CLK  input  1  free-running system clock
- RST  input  1  synchronous, active-high reset
- START  input  1  request clock enable; single-cycle or level
- STOP  input  1  request orderly disable
- MMCM_LOCKED  input  1  asynchronous lock from the source MMCM
- CE  output  1  to BUFMRCE.CE
- CLR  output  1  to BUFR.CLR, active high
- READY  output  1  buffered clock running and BUFRs released
- BUSY  output  1  sequence in progress (any state except IDLE and RUN)
- LOCK_LOST  output  1  sticky; lock dropped while not IDLE
- STATE  output  3  current state encoding

Behaviour:
- All outputs are registered. Reset values: CE=0, CLR=1, READY=0, BUSY=0, LOCK_LOST=0, STATE=IDLE. Synchronizer flops reset to 0.
- lock_s is MMCM_LOCKED after LOCK_SYNC flops. All decisions use lock_s.
- One 8-bit down-counter, loaded on each state entry.
- States and encoding:
  - IDLE (0): CE=0, CLR=1. START with lock_s=1 goes to CE_SETTLE; START with lock_s=0 goes to WAIT_LOCK. Accepting START clears LOCK_LOST.
  - WAIT_LOCK (1): CE=0, CLR=1. Goes to CE_SETTLE when lock_s=1.
  - CE_SETTLE (2): CE=0, CLR=1. Stays exactly CE_DLY cycles, then CE_ON.
  - CE_ON (3): CE=1, CLR=1. Stays exactly CLR_DLY cycles, then RUN.
  - RUN (4): CE=1, CLR=0, READY=1. STOP goes to STOP_CLR. START is ignored.
  - STOP_CLR (5): CE=1, CLR=1. Stays CLR_DLY cycles, then IDLE, where CE falls.
  - FAULT (6): CE=0, CLR=1. One cycle, then IDLE, or WAIT_LOCK if AUTO_RESTART=1.
- Timing: START sampled in IDLE at cycle t with lock_s=1:
  - CE rises at t+CE_DLY+1.
  - CLR falls and READY rises at t+CE_DLY+CLR_DLY+1.
- STOP in WAIT_LOCK, CE_SETTLE or CE_ON aborts straight to IDLE on the next cycle.
- START and STOP in the same cycle: STOP wins. In IDLE, the request is ignored.
- lock_s=0 in any state other than IDLE or WAIT_LOCK:
  - Next cycle is FAULT, with CE=0, CLR=1, READY=0.
  - LOCK_LOST set.
  - Lock loss takes priority over STOP.
- RST mid-sequence forces the reset values on the next edge. No orderly stop is performed.
- BUSY=1 in states 1, 2, 3, 5 and 6.

Optional Feature:
- Macro BUFMR_CE_SEQ_LOSS_CNT_EN.
- When defined: extra output LOSS_CNT [7:0].
  - Increments on each FAULT entry and saturates at 255.
  - Cleared only by RST; START does not clear it.
- When undefined: the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- Reset, MMCM_LOCKED=1, CE_DLY=4, CLR_DLY=8, START pulse at t -> CE=0 through t+4, CE=1 at t+5, CLR=0 and READY=1 at t+13, BUSY low from t+13.
- START with MMCM_LOCKED=0, lock raised 20 cycles later -> state 1 while unlocked; CE rises LOCK_SYNC+CE_DLY+1 cycles after lock asserts.
- In RUN, STOP pulse at t -> CLR=1 at t+1, CE=1 held through t+8, CE=0 and STATE=0 at t+9.
- In RUN, MMCM_LOCKED drops at t -> CE=0, CLR=1, READY=0 at t+LOCK_SYNC+1; LOCK_LOST=1; STATE=0 one cycle later. The next START clears LOCK_LOST. With the macro defined, LOSS_CNT=1.
- START and STOP asserted together in IDLE -> no state change. STOP during CE_SETTLE -> IDLE next cycle with CE never rising.
- AUTO_RESTART=1 with lock toggled off and on -> FAULT goes to WAIT_LOCK and resumes the full sequence. RST asserted in CE_ON -> all outputs return to their reset values next cycle.
